// File: rtl/ahb_wr_buffer_if.sv
// AHB-Lite slave bus plus memory port for ahb_wr_buffer; slave modport is the buffer's view.
// Latency: none, signal bundle only.
// Backpressure: carried by hreadyout (AHB) and mem_ack (memory side).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface ahb_wr_buffer_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
    logic [LW-1:0]         fifo_level;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hready, hwdata, mem_rdata, mem_ack,
        output hreadyout, hresp, hrdata, mem_req, mem_we, mem_addr, mem_wdata, fifo_level
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hready, hwdata, mem_rdata, mem_ack,
        input  hreadyout, hresp, hrdata, mem_req, mem_we, mem_addr, mem_wdata, fifo_level
    );
endinterface

// File: rtl/ahb_wr_buffer.sv
// AHB-Lite write buffer: posted writes queue in a FIFO and drain via mem_req/ack; optional AHB_ERR_RESP_EN.
// Latency: writes zero-wait; reads wait for the FIFO to drain, then one wait state with immediate ack.
// Backpressure: hreadyout drops on a full FIFO or an outstanding read; memory side throttles via mem_ack.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ahb_wr_buffer #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic            hclk,
    input logic            hreset,
    ahb_wr_buffer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_DRAIN,
        ST_RD_MEM,
        ST_RD_RESP
`ifdef AHB_ERR_RESP_EN
        , ST_ERR1,
        ST_ERR2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [WW-1:0]         fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q;

    logic accept, fifo_empty, fifo_full;
    logic ready, resp, push, pop, rd_mem, new_phase, drain_act;
    logic                  mem_req_c, mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic                  unused_bits;

    assign accept     = bus.hsel & bus.hready & bus.htrans[1];
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

`ifdef AHB_ERR_RESP_EN
    assign unused_bits = bus.htrans[0];
`else
    assign unused_bits = bus.htrans[0] ^ (^bus.haddr[1:0]);
`endif

    always_comb begin
        state_d   = state_q;
        ready     = 1'b1;
        resp      = 1'b0;
        push      = 1'b0;
        rd_mem    = 1'b0;
        new_phase = 1'b0;
        case (state_q)
            ST_IDLE:    new_phase = 1'b1;
            ST_WR_DATA: begin
                if (fifo_full) begin
                    ready = 1'b0;
                end else begin
                    push      = 1'b1;
                    new_phase = 1'b1;
                end
            end
            ST_RD_DRAIN: begin
                ready = 1'b0;
                if (fifo_empty) state_d = ST_RD_MEM;
            end
            ST_RD_MEM: begin
                ready  = 1'b0;
                rd_mem = 1'b1;
                if (bus.mem_ack) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: new_phase = 1'b1;
`ifdef AHB_ERR_RESP_EN
            ST_ERR1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                resp      = 1'b1;
                new_phase = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A read may only bypass the drain state if nothing is queued, including this cycle's push.
        if (new_phase) begin
            state_d = ST_IDLE;
            if (accept) begin
`ifdef AHB_ERR_RESP_EN
                if (bus.haddr[1:0] != 2'b00) state_d = ST_ERR1;
                else
`endif
                if (bus.hwrite)                state_d = ST_WR_DATA;
                else if (fifo_empty && !push)  state_d = ST_RD_MEM;
                else                           state_d = ST_RD_DRAIN;
            end
        end
    end

    assign drain_act = !fifo_empty && (state_q != ST_RD_MEM);
    assign pop       = drain_act && bus.mem_ack;

    always_comb begin
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (rd_mem) begin
            mem_req_c  = 1'b1;
            mem_addr_c = {addr_q, 2'b00};
        end else if (drain_act) begin
            mem_req_c   = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = {fifo_addr[rd_ptr], 2'b00};
            mem_wdata_c = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            hrdata_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            if (new_phase && accept) addr_q <= bus.haddr[ADDR_WIDTH-1:2];
            if (rd_mem && bus.mem_ack) hrdata_q <= bus.mem_rdata;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr_q;
            fifo_data[wr_ptr] <= bus.hwdata;
        end
    end

    assign bus.hreadyout  = ready;
    assign bus.hresp      = resp;
    assign bus.hrdata     = hrdata_q;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_ahb_wr_buffer.sv
// Bench for ahb_wr_buffer: directed scenarios plus random traffic against a word-array memory model.
module tb_ahb_wr_buffer;
    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_wr_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();

    ahb_wr_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          ack_mode = 0;
    logic        ack_en = 1'b0;
    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];
    logic [31:0] saved_mem [64];
    wr_t         wr_exp [$];
    logic [31:0] rd_exp [$];
    logic        xf_we   [256];
    logic [31:0] xf_addr [256];
    logic [31:0] xf_data [256];
    int          xf_wait [256];
    logic        xf_resp [256];
    logic        xf_resp0 [256];
    int          mem_wr_count = 0;
    int          req_cycles = 0;
    logic        dphase_rd = 1'b0;
    logic        prev_pend = 1'b0;
    logic [96:0] prev_req;

    assign bus.hready    = bus.hreadyout;
    assign bus.mem_ack   = bus.mem_req & ack_en;
    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:2]];

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {bus.hreadyout, bus.hresp, bus.mem_req, bus.mem_we}, 4'b1000);
        check({tag, "_hrdata"}, bus.hrdata, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_level"}, bus.fifo_level, 0);
    endtask

    task automatic set_xf(input int k, input logic we, input logic [31:0] addr, input logic [31:0] data);
        xf_we[k]   = we;
        xf_addr[k] = addr;
        xf_data[k] = data;
    endtask

    // Reference: memory is the sequence of accepted writes; a read sees every write accepted before it.
    task automatic model_accept(input int k);
        int  idx;
        wr_t e;
        idx = int'(xf_addr[k][7:2]);
`ifdef AHB_ERR_RESP_EN
        if (xf_addr[k][1:0] != 2'b00) return;
`endif
        if (xf_we[k]) begin
            ref_mem[idx] = xf_data[k];
            e.addr = {xf_addr[k][31:2], 2'b00};
            e.data = xf_data[k];
            wr_exp.push_back(e);
        end else begin
            rd_exp.push_back(ref_mem[idx]);
        end
    endtask

    // Pipelined AHB master: next address phase overlaps the current data phase.
    task automatic run_xfers(input int n);
        int a = 0;
        int d = -1;
        int w = 0;
        int guard = 0;
        @(posedge hclk);
        #1;
        while ((a < n || d >= 0) && guard < 5000) begin
            bus.hwdata = (d >= 0 && xf_we[d]) ? xf_data[d] : 32'h0;
            if (a < n) begin
                bus.htrans = 2'b10;
                bus.haddr  = xf_addr[a];
                bus.hwrite = xf_we[a];
            end else begin
                bus.htrans = 2'b00;
            end
            @(negedge hclk);
            if (d >= 0 && w == 0) xf_resp0[d] = bus.hresp;
            if (bus.hreadyout) begin
                if (d >= 0) begin
                    xf_wait[d] = w;
                    xf_resp[d] = bus.hresp;
                end
                w = 0;
                if (a < n) begin
                    model_accept(a);
                    d = a;
                    a++;
                end else begin
                    d = -1;
                end
            end else begin
                w++;
            end
            guard++;
            @(posedge hclk);
            #1;
        end
        bus.htrans = 2'b00;
        if (guard >= 5000) check("xfer_timeout", guard, 0);
    endtask

    task automatic wait_level_zero(input int budget, input string name);
        int c = 0;
        @(negedge hclk);
        while (bus.fifo_level != 0 && c < budget) begin
            @(negedge hclk);
            c++;
        end
        check(name, bus.fifo_level, 0);
    endtask

    initial begin
        logic nxt;
        forever begin
            @(negedge hclk);
            case (ack_mode)
                0:       nxt = 1'b0;
                1:       nxt = 1'b1;
                2:       nxt = bus.mem_req & ~bus.mem_ack;
                default: nxt = 1'($urandom_range(0, 1));
            endcase
            @(posedge hclk);
            #1;
            ack_en = nxt;
        end
    end

    // Memory-side monitor: write order, handshake stability, memory image.
    always @(negedge hclk) begin
        if (hreset) begin
            prev_pend = 1'b0;
        end else begin
            if (bus.mem_req) req_cycles++;
            if (prev_pend)
                check("mem_hold", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, prev_req);
            if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
                mem_wr_count++;
                if (wr_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_wr_unexpected: got %0h/%0h, want no write", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_t e;
                    e = wr_exp.pop_front();
                    check("mem_wr", {bus.mem_addr, bus.mem_wdata}, {e.addr, e.data});
                end
                tb_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
            end
            prev_pend = bus.mem_req & ~bus.mem_ack;
            prev_req  = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        end
    end

    // AHB read-data monitor.
    always @(negedge hclk) begin
        if (hreset) begin
            dphase_rd = 1'b0;
        end else begin
            if (dphase_rd && bus.hreadyout) begin
                dphase_rd = 1'b0;
                if (!bus.hresp) begin
                    if (rd_exp.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_unexpected: got %0h, want no read", bus.hrdata);
                    end else begin
                        check("rd_data", bus.hrdata, rd_exp.pop_front());
                    end
                end
            end
            if (bus.hsel && bus.hready && bus.htrans[1] && !bus.hwrite) dphase_rd = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.hsel   = 1'b1;
        bus.htrans = 2'b00;
        bus.haddr  = 32'h0;
        bus.hwrite = 1'b0;
        bus.hwdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check_reset_vals("por");
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // Single posted write, ack one cycle after request.
        ack_mode = 2;
        set_xf(0, 1'b1, 32'h10, 32'hA5A5_0001);
        run_xfers(1);
        check("t1_wait", xf_wait[0], 0);
        check("t1_resp", xf_resp[0], 0);
        @(negedge hclk);
        check("t1_level1", bus.fifo_level, 1);
        check("t1_req", {bus.mem_req, bus.mem_we}, 2'b11);
        wait_level_zero(10, "t1_level0");
        check("t1_count", mem_wr_count, 1);
        check("t1_mem", tb_mem[4], 32'hA5A5_0001);

        // Fill the FIFO with ack held low; fifth write must stall.
        ack_mode = 0;
        repeat (2) @(posedge hclk);
        for (int k = 0; k < 5; k++) set_xf(k, 1'b1, 32'h80 + 32'(k * 4), $urandom);
        fork
            run_xfers(5);
            begin
                repeat (10) @(negedge hclk);
                check("t2_full_level", bus.fifo_level, 4);
                check("t2_stall", bus.hreadyout, 0);
                ack_mode = 2;
            end
        join
        for (int k = 0; k < 4; k++) check("t2_zero_wait", xf_wait[k], 0);
        check("t2_fifth_stalled", xf_wait[4] > 0, 1);
        wait_level_zero(40, "t2_level0");
        check("t2_count", mem_wr_count, 6);

        // Read-after-write to the same address waits for the drain.
        set_xf(0, 1'b1, 32'h20, 32'h0000_1234);
        set_xf(1, 1'b0, 32'h20, 32'h0);
        run_xfers(2);
        check("t3_rd_stall", xf_wait[1] >= 2, 1);
        check("t3_hrdata", bus.hrdata, 32'h0000_1234);

        // Read with empty FIFO and immediate ack: exactly one wait state.
        ack_mode = 1;
        repeat (2) @(posedge hclk);
        set_xf(0, 1'b0, 32'h40, 32'h0);
        run_xfers(1);
        check("t4_wait", xf_wait[0], 1);
        check("t4_hrdata", bus.hrdata, ref_mem[16]);

        // Reset with queued writes and an open request.
        ack_mode = 0;
        repeat (2) @(posedge hclk);
        saved_mem = ref_mem;
        for (int k = 0; k < 3; k++) set_xf(k, 1'b1, 32'(k * 4), $urandom);
        run_xfers(3);
        @(negedge hclk);
        check("t5_level3", bus.fifo_level, 3);
        check("t5_req", bus.mem_req, 1);
        @(posedge hclk);
        #1;
        hreset = 1'b1;
        @(negedge hclk);
        check_reset_vals("midrst");
        wr_exp.delete();
        ref_mem = saved_mem;
        cnt = mem_wr_count;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        ack_mode = 1;
        repeat (10) @(negedge hclk);
        check("t5_no_write", mem_wr_count, cnt);
        check("t5_level", bus.fifo_level, 0);

`ifdef AHB_ERR_RESP_EN
        // Misaligned write: two-cycle ERROR, nothing queued, no memory traffic.
        cnt = req_cycles;
        set_xf(0, 1'b1, 32'h13, 32'hDEAD_BEEF);
        run_xfers(1);
        check("err_wait", xf_wait[0], 1);
        check("err_resp1", xf_resp0[0], 1);
        check("err_resp2", xf_resp[0], 1);
        repeat (3) @(negedge hclk);
        check("err_level", bus.fifo_level, 0);
        check("err_no_req", req_cycles, cnt);
`endif

        // Random mixed traffic with random ack timing on a small address window.
        ack_mode = 3;
        for (int k = 0; k < 150; k++)
            set_xf(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        run_xfers(150);
        wait_level_zero(200, "t6_level0");
        repeat (3) @(negedge hclk);
        check("t6_rd_queue", rd_exp.size(), 0);
        check("t6_wr_queue", wr_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
